// File: rtl/output_result_buffer_pkg.sv
// output_result_buffer_pkg
//   Shared types and helpers for the multi-channel output result buffer.
//   - wr_state_e   : writer FSM states (IDLE, FLUSH, DONE)
//   - narrow_result: reduces an unsigned result to 'width' bits by saturation or truncation
//   - exceeds_limit: true when an unsigned result does not fit in 'width' bits
package output_result_buffer_pkg;

    localparam int SAT_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

    function automatic logic [31:0] narrow_result(input logic [31:0] value,
                                                  input logic        sat,
                                                  input int unsigned width);
        logic [31:0] limit;
        limit = (32'd1 << width) - 32'd1;
        if (sat) begin
            return (value > limit) ? limit : value;
        end
        return value & limit;
    endfunction

    function automatic logic exceeds_limit(input logic [31:0] value,
                                           input int unsigned width);
        return value > ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/output_result_buffer_rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter. The search starts at the channel after the last
//   granted one; after reset channel 0 has highest priority. The pointer only
//   moves when 'en' is high and some request is granted.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     req      : request bits, one per channel
//     en       : grant is actually consumed this cycle
//     grant    : one-hot grant (valid whenever req is non-zero)
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              en,
    output logic [NUM_CH-1:0] grant
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [IDX_W-1:0] last_q, last_d;

    always_comb begin
        int  idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        grant  = '0;
        last_d = last_q;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(last_q) + i) % NUM_CH;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                if (en) begin
                    last_d = IDX_W'(idx);
                end
            end
        end
    end

    // Resetting to the last channel makes channel 0 the first one searched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IDX_W'(NUM_CH - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/output_result_buffer.sv
// output_result_buffer
//   Collects results from NUM_CH engines into one-entry holding slots,
//   narrows them to DATA_WIDTH (saturate or truncate), and writes one slot per
//   cycle into a result memory in round-robin order. A flush request drains the
//   slots and then pulses writer_done. Reads have a fixed one-cycle latency.
//   Optional build macro: OUTPUT_BUFFER_SAT_COUNT_EN adds the sat_count output.
//   Ports:
//     clk, rst                      : clock, asynchronous active-high reset
//     result_in/valid/ready         : per-channel result handshake
//     sat_mode                      : 1 saturate, 0 truncate (sampled at transfer)
//     clear_ptr                     : rewind write pointer to address 0
//     processing_done               : start flush
//     read_en, read_addr            : read request
//     result_out, read_valid        : read data, one cycle after read_en
//     result_count, buf_full        : words written since clear, memory full
//     writer_busy, writer_done      : slots/flush in progress, end-of-flush pulse
//     sat_count (optional)          : saturating count of clipped transfers
module output_result_buffer #(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH + $clog2(VECTOR_WIDTH),
    parameter int NUM_CH       = 4,
    parameter int MEM_SIZE     = 64,
    parameter int ADDR_WIDTH   = $clog2(MEM_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH*RESULT_WIDTH-1:0] result_in,
    input  logic [NUM_CH-1:0]              result_valid,
    output logic [NUM_CH-1:0]              result_ready,
    input  logic                           sat_mode,
    input  logic                           clear_ptr,
    input  logic                           processing_done,
    input  logic                           read_en,
    input  logic [ADDR_WIDTH-1:0]          read_addr,
    output logic [DATA_WIDTH-1:0]          result_out,
    output logic                           read_valid,
    output logic [ADDR_WIDTH:0]            result_count,
    output logic                           buf_full,
    output logic                           writer_busy,
    output logic                           writer_done
`ifdef OUTPUT_BUFFER_SAT_COUNT_EN
    ,
    output logic [15:0]                    sat_count
`endif
);

    import output_result_buffer_pkg::*;

    logic [NUM_CH-1:0]       slot_full_q, slot_full_d;
    logic [DATA_WIDTH-1:0]   slot_data_q [NUM_CH];
    logic [DATA_WIDTH-1:0]   slot_data_d [NUM_CH];
    logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
    wr_state_e               state_q, state_d;
    logic [DATA_WIDTH-1:0]   result_out_q, result_out_d;
    logic                    read_valid_q, read_valid_d;
    logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];

    logic [RESULT_WIDTH-1:0] res_ch [NUM_CH];
    logic [NUM_CH-1:0]       grant;
    logic [NUM_CH-1:0]       take;
    logic                    write_en;
    logic [DATA_WIDTH-1:0]   wr_data;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_res
        assign res_ch[c] = result_in[c*RESULT_WIDTH +: RESULT_WIDTH];
    end

    // Ready depends on slot occupancy only, so a freed slot reappears as ready
    // one cycle after its write.
    assign result_ready = ~slot_full_q;
    assign take         = result_valid & result_ready;
    assign buf_full     = (wr_ptr_q == (ADDR_WIDTH+1)'(MEM_SIZE));
    assign write_en     = !buf_full && (|slot_full_q);

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (slot_full_q),
        .en    (write_en),
        .grant (grant)
    );

    always_comb begin
        slot_full_d = slot_full_q;
        wr_data     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            slot_data_d[c] = slot_data_q[c];
            if (write_en && grant[c]) begin
                slot_full_d[c] = 1'b0;
                wr_data        = wr_data | slot_data_q[c];
            end
            // take[c] implies the slot is empty, so it never collides with its grant.
            if (take[c]) begin
                slot_full_d[c] = 1'b1;
                slot_data_d[c] = DATA_WIDTH'(narrow_result(32'(res_ch[c]), sat_mode, DATA_WIDTH));
            end
        end
    end

    // A coincident write still uses the old pointer; clear takes precedence for the new one.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (clear_ptr) begin
            wr_ptr_d = '0;
        end else if (write_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (processing_done) state_d = ST_FLUSH;
            ST_FLUSH: if (!(|slot_full_q) || buf_full) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        result_out_d = result_out_q;
        read_valid_d = read_en;
        if (read_en) begin
            if (32'(read_addr) < 32'(MEM_SIZE)) begin
                result_out_d = mem[read_addr];
            end else begin
                result_out_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_full_q  <= '0;
            wr_ptr_q     <= '0;
            state_q      <= ST_IDLE;
            result_out_q <= '0;
            read_valid_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                slot_data_q[c] <= '0;
            end
        end else begin
            slot_full_q  <= slot_full_d;
            wr_ptr_q     <= wr_ptr_d;
            state_q      <= state_d;
            result_out_q <= result_out_d;
            read_valid_q <= read_valid_d;
            for (int c = 0; c < NUM_CH; c++) begin
                slot_data_q[c] <= slot_data_d[c];
            end
        end
    end

    // Result memory: not reset. The read path above samples the pre-write value.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    assign result_out   = result_out_q;
    assign read_valid   = read_valid_q;
    assign result_count = wr_ptr_q;
    assign writer_done  = (state_q == ST_DONE);
    assign writer_busy  = (|slot_full_q) || (state_q == ST_FLUSH);

`ifdef OUTPUT_BUFFER_SAT_COUNT_EN
    logic [SAT_COUNT_WIDTH-1:0] sat_count_q, sat_count_d;
    logic [SAT_COUNT_WIDTH:0]   sat_sum;

    always_comb begin
        sat_sum = {1'b0, sat_count_q};
        for (int c = 0; c < NUM_CH; c++) begin
            if (take[c] && sat_mode && exceeds_limit(32'(res_ch[c]), DATA_WIDTH)) begin
                sat_sum = sat_sum + 1'b1;
            end
        end
        sat_count_d = sat_sum[SAT_COUNT_WIDTH] ? '1 : sat_sum[SAT_COUNT_WIDTH-1:0];
        if (clear_ptr) begin
            sat_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;
`endif

endmodule
